// File: rtl/otter_pkg.sv
// Shared OTTER definitions: RV32I major opcodes, SYSTEM FUNC3 codes and the
// control-unit state encoding. Also imported by the combinational decoder.
package otter_pkg;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_BRANCH = 7'b1100011,
        OPC_OP     = 7'b0110011,
        OPC_OP_IMM = 7'b0010011,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_SYSTEM = 7'b1110011
    } opcode_t;

    localparam logic [2:0] F3_MRET  = 3'b000;
    localparam logic [2:0] F3_CSRRW = 3'b001;
    localparam logic [2:0] F3_CSRRS = 3'b010;
    localparam logic [2:0] F3_CSRRC = 3'b011;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_INTR  = 3'd4
    } cu_state_t;

endpackage

// File: rtl/cu_fsm.sv
// Multicycle OTTER control unit: sequences FETCH/EXEC/WB per instruction and
// enters the interrupt state only on an instruction's final cycle.
//
//  state    | meaning
//  ST_INIT  | reset held to PC and register file
//  ST_FETCH | instruction memory read, FETCH_WAIT cycles
//  ST_EXEC  | execute; final cycle for everything except loads
//  ST_WB    | load data written back to register file
//  ST_INTR  | one-cycle trap entry, PC loaded from mtvec
module cu_fsm
    import otter_pkg::*;
#(
    parameter int unsigned FETCH_WAIT = 1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [6:0] OPCODE,
    input  logic [2:0] FUNC3,
    input  logic       INTR,
    input  logic       CSR_MIE,
    output logic       RST_OUT,
    output logic       PC_WE,
    output logic       REG_WE,
    output logic       MEM_RDEN1,
    output logic       MEM_RDEN2,
    output logic       MEM_WE2,
    output logic       CSR_WE,
    output logic       INT_TAKEN,
    output logic       MRET_EXEC,
    output logic       RETIRED
);

    localparam logic [3:0] FW_LAST = 4'(FETCH_WAIT - 1);

    cu_state_t  state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic       intr_go;

    assign intr_go = INTR && CSR_MIE;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_INIT;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            ST_INIT:  state_d = ST_FETCH;
            ST_FETCH: begin
                if (wait_q == FW_LAST) begin
                    wait_d  = '0;
                    state_d = ST_EXEC;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            ST_EXEC: begin
                // Loads defer interrupt sampling to their WB cycle.
                if (OPCODE == OPC_LOAD) state_d = ST_WB;
                else                    state_d = intr_go ? ST_INTR : ST_FETCH;
            end
            ST_WB:    state_d = intr_go ? ST_INTR : ST_FETCH;
            ST_INTR:  state_d = ST_FETCH;
            default: begin
                state_d = ST_INIT;
                wait_d  = '0;
            end
        endcase
    end

    always_comb begin
        RST_OUT   = 1'b0;
        PC_WE     = 1'b0;
        REG_WE    = 1'b0;
        MEM_RDEN1 = 1'b0;
        MEM_RDEN2 = 1'b0;
        MEM_WE2   = 1'b0;
        CSR_WE    = 1'b0;
        INT_TAKEN = 1'b0;
        MRET_EXEC = 1'b0;
        RETIRED   = 1'b0;
        case (state_q)
            ST_INIT:  RST_OUT = 1'b1;
            ST_FETCH: MEM_RDEN1 = 1'b1;
            ST_EXEC: begin
                if (OPCODE == OPC_LOAD) begin
                    MEM_RDEN2 = 1'b1;
                end else begin
                    PC_WE   = 1'b1;
                    RETIRED = 1'b1;
                    case (OPCODE)
                        OPC_STORE: MEM_WE2 = 1'b1;
                        OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR:
                            REG_WE = 1'b1;
                        OPC_SYSTEM: begin
                            if (FUNC3 == F3_CSRRW || FUNC3 == F3_CSRRS || FUNC3 == F3_CSRRC) begin
                                CSR_WE = 1'b1;
                                REG_WE = 1'b1;
                            end else if (FUNC3 == F3_MRET) begin
                                MRET_EXEC = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_WB: begin
                REG_WE  = 1'b1;
                PC_WE   = 1'b1;
                RETIRED = 1'b1;
            end
            ST_INTR: begin
                INT_TAKEN = 1'b1;
                PC_WE     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cu_fsm.sv
// Scoreboard bench for cu_fsm: two instances (FETCH_WAIT 1 and 3), per-cycle
// expected strobe vectors queued by the instruction-level model.
module tb_cu_fsm;

    localparam logic [9:0] M_RST  = 10'h200;
    localparam logic [9:0] M_PC   = 10'h100;
    localparam logic [9:0] M_REG  = 10'h080;
    localparam logic [9:0] M_RD1  = 10'h040;
    localparam logic [9:0] M_RD2  = 10'h020;
    localparam logic [9:0] M_WE2  = 10'h010;
    localparam logic [9:0] M_CSR  = 10'h008;
    localparam logic [9:0] M_INT  = 10'h004;
    localparam logic [9:0] M_MRET = 10'h002;
    localparam logic [9:0] M_RET  = 10'h001;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] ADDI   = 7'b0010011;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    logic       clk = 1'b0;
    logic       rst_n [2];
    logic [6:0] opc   [2];
    logic [2:0] f3    [2];
    logic       intr  [2];
    logic       mie   [2];
    logic [9:0] ov0, ov1;

    logic [9:0] expq0[$];
    logic [9:0] expq1[$];
    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    cu_fsm #(.FETCH_WAIT(1)) dut0 (
        .CLK(clk), .RST_N(rst_n[0]), .OPCODE(opc[0]), .FUNC3(f3[0]),
        .INTR(intr[0]), .CSR_MIE(mie[0]),
        .RST_OUT(ov0[9]), .PC_WE(ov0[8]), .REG_WE(ov0[7]), .MEM_RDEN1(ov0[6]),
        .MEM_RDEN2(ov0[5]), .MEM_WE2(ov0[4]), .CSR_WE(ov0[3]), .INT_TAKEN(ov0[2]),
        .MRET_EXEC(ov0[1]), .RETIRED(ov0[0])
    );

    cu_fsm #(.FETCH_WAIT(3)) dut1 (
        .CLK(clk), .RST_N(rst_n[1]), .OPCODE(opc[1]), .FUNC3(f3[1]),
        .INTR(intr[1]), .CSR_MIE(mie[1]),
        .RST_OUT(ov1[9]), .PC_WE(ov1[8]), .REG_WE(ov1[7]), .MEM_RDEN1(ov1[6]),
        .MEM_RDEN2(ov1[5]), .MEM_WE2(ov1[4]), .CSR_WE(ov1[3]), .INT_TAKEN(ov1[2]),
        .MRET_EXEC(ov1[1]), .RETIRED(ov1[0])
    );

    // Strobes seen in the final cycle of a non-load instruction.
    function automatic logic [9:0] exec_vec(input logic [6:0] o, input logic [2:0] f);
        case (o)
            STORE:         return M_WE2 | M_PC | M_RET;
            7'b1100011:    return M_PC | M_RET;
            7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111:
                           return M_REG | M_PC | M_RET;
            SYSTEM: begin
                if (f == 3'b001 || f == 3'b010 || f == 3'b011) return M_CSR | M_REG | M_PC | M_RET;
                if (f == 3'b000) return M_MRET | M_PC | M_RET;
                return M_PC | M_RET;
            end
            default:       return M_PC | M_RET;
        endcase
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push_exp(input int d, input logic [9:0] v);
        if (d == 0) expq0.push_back(v);
        else        expq1.push_back(v);
    endtask

    // Apply inputs for one cycle (called at posedge+1) and queue the expected strobes.
    task automatic drive(input int d, input logic [6:0] o, input logic [2:0] f,
                         input logic i, input logic m, input logic [9:0] v);
        opc[d]  = o;
        f3[d]   = f;
        intr[d] = i;
        mie[d]  = m;
        push_exp(d, v);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int d);
        rst_n[d] = 1'b0;
        for (int k = 0; k < 3; k++) drive(d, 7'd0, 3'd0, rbit(), rbit(), M_RST);
        rst_n[d] = 1'b1;
        drive(d, 7'd0, 3'd0, rbit(), rbit(), M_RST);
    endtask

    task automatic instr(input int d, input int fw, input logic [6:0] o, input logic [2:0] f,
                         input logic fi, input logic fm);
        for (int k = 0; k < fw; k++) drive(d, o, f, rbit(), rbit(), M_RD1);
        if (o == LOAD) begin
            drive(d, o, f, rbit(), rbit(), M_RD2);
            drive(d, o, f, fi, fm, M_REG | M_PC | M_RET);
        end else begin
            drive(d, o, f, fi, fm, exec_vec(o, f));
        end
        if (fi && fm) drive(d, o, f, rbit(), rbit(), M_INT | M_PC);
    endtask

    // Reset asserted partway through a load's WB cycle, then restart.
    task automatic reset_in_wb(input int d, input int fw);
        for (int k = 0; k < fw; k++) drive(d, LOAD, 3'd2, rbit(), rbit(), M_RD1);
        drive(d, LOAD, 3'd2, 1'b1, 1'b1, M_RD2);
        opc[d] = LOAD; intr[d] = 1'b1; mie[d] = 1'b1;
        push_exp(d, M_RST);
        #2 rst_n[d] = 1'b0;
        @(posedge clk);
        #1;
        drive(d, LOAD, 3'd2, 1'b1, 1'b1, M_RST);
        drive(d, LOAD, 3'd2, 1'b1, 1'b1, M_RST);
        rst_n[d] = 1'b1;
        drive(d, LOAD, 3'd2, 1'b0, 1'b0, M_RST);
        instr(d, fw, ADDI, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic rand_instr(input int d, input int fw);
        logic [6:0] ops [11];
        logic [6:0] o;
        ops = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b0110011, 7'b0010011, 7'b0110111,
                7'b0010111, 7'b1101111, 7'b1100111, 7'b1110011, 7'b1110011};
        o = ($urandom_range(0, 7) == 0) ? 7'($urandom) : ops[$urandom_range(0, 10)];
        instr(d, fw, o, 3'($urandom), rbit(), rbit());
    endtask

    always @(negedge clk) begin
        logic [9:0] e;
        if (expq0.size() > 0) begin
            e = expq0.pop_front();
            compared++;
            if (ov0 !== e) begin
                mismatched++;
                $display("FAIL fw1_strobes t=%0t actual=%b required=%b", $time, ov0, e);
            end
        end
        if (expq1.size() > 0) begin
            e = expq1.pop_front();
            compared++;
            if (ov1 !== e) begin
                mismatched++;
                $display("FAIL fw3_strobes t=%0t actual=%b required=%b", $time, ov1, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; opc[d] = '0; f3[d] = '0; intr[d] = 1'b0; mie[d] = 1'b0;
        end
        @(posedge clk);
        #1;

        do_reset(0);
        for (int k = 0; k < 10; k++) instr(0, 1, ADDI, 3'($urandom), 1'b0, rbit());
        instr(0, 1, LOAD, 3'd2, 1'b0, 1'b1);
        instr(0, 1, STORE, 3'd2, 1'b1, 1'b1);
        instr(0, 1, STORE, 3'd2, 1'b1, 1'b0);
        instr(0, 1, SYSTEM, 3'b000, 1'b1, 1'b0);
        instr(0, 1, ADDI, 3'd0, 1'b1, 1'b1);
        instr(0, 1, LOAD, 3'd2, 1'b1, 1'b1);
        for (int k = 0; k < 80; k++) rand_instr(0, 1);
        reset_in_wb(0, 1);

        do_reset(1);
        instr(1, 3, LOAD, 3'd2, 1'b0, 1'b0);
        instr(1, 3, STORE, 3'd0, 1'b1, 1'b1);
        for (int k = 0; k < 40; k++) rand_instr(1, 3);
        reset_in_wb(1, 3);

        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
